// File: rtl/bin_frame_streamer.sv
// bin_frame_streamer: writer-side front end for the 8-bit bin-value delay line.
// On a start pulse, reads num_bins values from a synchronous-read memory and
// streams them one per cycle into the delay line. A valid shadow register of
// delay_depth bits tracks which delay-line taps hold real frame data.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start            single-cycle frame request, honoured only in IDLE
//   mem_rd_en        memory read strobe
//   mem_addr         memory read address
//   mem_rdata        memory read data, valid one cycle after mem_rd_en
//   shift_value_out  value presented to the delay line (0 when not valid)
//   shift_valid      shift_value_out holds a frame element
//   frame_last       marks element num_bins-1 on shift_value_out
//   tap_valid_a/b    delay-line tap A / tap B holds a frame element
//   busy             frame in progress (READ or DRAIN)
//   done             one-cycle completion pulse
module bin_frame_streamer #(
  parameter int num_bins    = 1024,
  parameter int delay_depth = 2,
  parameter int addr_w      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [addr_w-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        shift_value_out,
  output logic              shift_valid,
  output logic              frame_last,
  output logic              tap_valid_a,
  output logic              tap_valid_b,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [addr_w-1:0] LAST_ADDR = addr_w'(num_bins - 1);
  // Drain counter runs 0..delay_depth+1, i.e. delay_depth+2 cycles.
  localparam int CNT_W = $clog2(delay_depth + 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(delay_depth + 1);

  state_t              state, state_next;
  logic [addr_w-1:0]   addr;
  logic [CNT_W-1:0]    drain_cnt;
  logic                rd_d1, last_d1;
  logic [7:0]          value_q;
  logic                valid_q, last_q;
  logic [delay_depth-1:0] shadow;

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        if (addr == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      drain_cnt <= '0;
      rd_d1     <= 1'b0;
      last_d1   <= 1'b0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state <= state_next;

      if (state == READ && addr != LAST_ADDR) addr <= addr + 1'b1;
      else                                    addr <= '0;

      if (state == DRAIN && drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
      else                                           drain_cnt <= '0;

      // Two-stage data path: read strobe -> memory output -> captured value.
      rd_d1   <= mem_rd_en;
      last_d1 <= mem_rd_en && (addr == LAST_ADDR);
      valid_q <= rd_d1;
      last_q  <= last_d1;
      value_q <= rd_d1 ? mem_rdata : '0;
    end
  end

  // Valid shadow of the downstream delay line, fed by shift_valid.
  if (delay_depth == 1) begin : g_shadow_one
    always_ff @(posedge clk) begin
      if (rst) shadow <= '0;
      else     shadow <= valid_q;
    end
  end else begin : g_shadow_many
    always_ff @(posedge clk) begin
      if (rst) shadow <= '0;
      else     shadow <= {shadow[delay_depth-2:0], valid_q};
    end
  end

  assign mem_addr        = addr;
  assign shift_value_out = value_q;
  assign shift_valid     = valid_q;
  assign frame_last      = last_q;
  assign tap_valid_a     = shadow[0];
  assign tap_valid_b     = shadow[delay_depth-1];

endmodule

// File: tb/tb_bin_frame_streamer.sv
// Bench for bin_frame_streamer: three instances (4 bins/depth 2, 4 bins/depth 5,
// 1 bin/depth 1) share clock, reset and start; a per-cycle expectation table
// covers the frame timing, plus hand sequences for ignored starts and aborts.
module tb_bin_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;

  logic       rd0, val0, last0, ta0, tb0, busy0, done0;
  logic [1:0] addr0;
  logic [7:0] rdata0, sv0;
  logic       rd1, val1, last1, ta1, tb1, busy1, done1;
  logic [1:0] addr1;
  logic [7:0] rdata1, sv1;
  logic       rd2, val2, last2, ta2, tb2, busy2, done2;
  logic [0:0] addr2;
  logic [7:0] rdata2, sv2;

  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];
  logic [7:0] mem2 [2];

  bin_frame_streamer #(.num_bins(4), .delay_depth(2), .addr_w(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(rd0), .mem_addr(addr0),
    .mem_rdata(rdata0), .shift_value_out(sv0), .shift_valid(val0),
    .frame_last(last0), .tap_valid_a(ta0), .tap_valid_b(tb0),
    .busy(busy0), .done(done0));

  bin_frame_streamer #(.num_bins(4), .delay_depth(5), .addr_w(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(rd1), .mem_addr(addr1),
    .mem_rdata(rdata1), .shift_value_out(sv1), .shift_valid(val1),
    .frame_last(last1), .tap_valid_a(ta1), .tap_valid_b(tb1),
    .busy(busy1), .done(done1));

  bin_frame_streamer #(.num_bins(1), .delay_depth(1), .addr_w(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(rd2), .mem_addr(addr2),
    .mem_rdata(rdata2), .shift_value_out(sv2), .shift_valid(val2),
    .frame_last(last2), .tap_valid_a(ta2), .tap_valid_b(tb2),
    .busy(busy2), .done(done2));

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd0) rdata0 <= mem0[addr0];
    if (rd1) rdata1 <= mem1[addr1];
    if (rd2) rdata2 <= mem2[addr2];
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rd;
    int         addr;
    logic [7:0] sv;
    logic       val, last, ta, tb, busy, done;
    logic       tb1, busy1, done1;
    logic       rd2;
    logic [7:0] sv2;
    logic       val2, ta2, busy2, done2;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic rd, int addr, logic [7:0] sv, logic val, logic last,
                              logic ta, logic tb, logic busy, logic done,
                              logic tb_1, logic busy_1, logic done_1,
                              logic rd_2, logic [7:0] sv_2, logic val_2, logic ta_2,
                              logic busy_2, logic done_2);
    vec_t v;
    v.rd = rd; v.addr = addr; v.sv = sv; v.val = val; v.last = last;
    v.ta = ta; v.tb = tb; v.busy = busy; v.done = done;
    v.tb1 = tb_1; v.busy1 = busy_1; v.done1 = done_1;
    v.rd2 = rd_2; v.sv2 = sv_2; v.val2 = val_2; v.ta2 = ta_2;
    v.busy2 = busy_2; v.done2 = done_2;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_idle(input string name, input int cyc);
    chk({name, "_u0"}, cyc, 32'({rd0, addr0, sv0, val0, last0, ta0, tb0, busy0, done0}), 32'd0);
    chk({name, "_u1"}, cyc, 32'({rd1, addr1, sv1, val1, last1, ta1, tb1, busy1, done1}), 32'd0);
    chk({name, "_u2"}, cyc, 32'({rd2, addr2, sv2, val2, last2, ta2, tb2, busy2, done2}), 32'd0);
  endtask

  task automatic run_table(input string tag);
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      @(negedge clk);
      chk({tag, "_rd"},    c, 32'(rd0),   32'(tbl[c].rd));
      chk({tag, "_addr"},  c, 32'(addr0), 32'(tbl[c].addr));
      chk({tag, "_sv"},    c, 32'(sv0),   32'(tbl[c].sv));
      chk({tag, "_val"},   c, 32'(val0),  32'(tbl[c].val));
      chk({tag, "_last"},  c, 32'(last0), 32'(tbl[c].last));
      chk({tag, "_ta"},    c, 32'(ta0),   32'(tbl[c].ta));
      chk({tag, "_tb"},    c, 32'(tb0),   32'(tbl[c].tb));
      chk({tag, "_busy"},  c, 32'(busy0), 32'(tbl[c].busy));
      chk({tag, "_done"},  c, 32'(done0), 32'(tbl[c].done));
      chk({tag, "_d5_rd"},   c, 32'(rd1),   32'(tbl[c].rd));
      chk({tag, "_d5_addr"}, c, 32'(addr1), 32'(tbl[c].addr));
      chk({tag, "_d5_sv"},   c, 32'(sv1),   32'(tbl[c].sv));
      chk({tag, "_d5_val"},  c, 32'(val1),  32'(tbl[c].val));
      chk({tag, "_d5_last"}, c, 32'(last1), 32'(tbl[c].last));
      chk({tag, "_d5_ta"},   c, 32'(ta1),   32'(tbl[c].ta));
      chk({tag, "_d5_tb"},   c, 32'(tb1),   32'(tbl[c].tb1));
      chk({tag, "_d5_busy"}, c, 32'(busy1), 32'(tbl[c].busy1));
      chk({tag, "_d5_done"}, c, 32'(done1), 32'(tbl[c].done1));
      chk({tag, "_n1_rd"},   c, 32'(rd2),   32'(tbl[c].rd2));
      chk({tag, "_n1_addr"}, c, 32'(addr2), 32'd0);
      chk({tag, "_n1_sv"},   c, 32'(sv2),   32'(tbl[c].sv2));
      chk({tag, "_n1_val"},  c, 32'(val2),  32'(tbl[c].val2));
      chk({tag, "_n1_last"}, c, 32'(last2), 32'(tbl[c].val2));
      chk({tag, "_n1_ta"},   c, 32'(ta2),   32'(tbl[c].ta2));
      chk({tag, "_n1_tb"},   c, 32'(tb2),   32'(tbl[c].ta2));
      chk({tag, "_n1_busy"}, c, 32'(busy2), 32'(tbl[c].busy2));
      chk({tag, "_n1_done"}, c, 32'(done2), 32'(tbl[c].done2));
    end
  endtask

  initial begin
    int n_rd0, n_rd1, n_rd2, n_done0, n_done1, n_done2, n_done_abort;

    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h33; mem0[3] = 8'h44;
    mem1[0] = 8'h11; mem1[1] = 8'h22; mem1[2] = 8'h33; mem1[3] = 8'h44;
    mem2[0] = 8'hA5; mem2[1] = 8'h00;

    //              rd addr sv    val lst ta tb bsy dn  tb1 bs1 dn1 rd2 sv2   v2 ta2 bs2 dn2
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0,  0, 1, 0,  1, 8'h00, 0, 0, 1, 0);
    tbl[2]  = mk(1, 1, 8'h00, 0, 0, 0, 0, 1, 0,  0, 1, 0,  0, 8'h00, 0, 0, 1, 0);
    tbl[3]  = mk(1, 2, 8'h11, 1, 0, 0, 0, 1, 0,  0, 1, 0,  0, 8'hA5, 1, 0, 1, 0);
    tbl[4]  = mk(1, 3, 8'h22, 1, 0, 1, 0, 1, 0,  0, 1, 0,  0, 8'h00, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 8'h33, 1, 0, 1, 1, 1, 0,  0, 1, 0,  0, 8'h00, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 8'h44, 1, 1, 1, 1, 1, 0,  0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0,  0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0,  1, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1,  1, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 8'h00, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 8'h00, 0, 0, 0, 0);

    // Reset then idle.
    rst = 1'b1; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_idle("reset", c);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset", 0);

    // Basic frame timing across all three configurations.
    run_table("frame");

    // Starts while busy or in DONE are ignored (u2 is idle again at cycle 9).
    n_rd0 = 0; n_rd1 = 0; n_rd2 = 0; n_done0 = 0; n_done1 = 0; n_done2 = 0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      start = (c == 0 || c == 2 || c == 9);
      @(negedge clk);
      n_rd0 += int'(rd0); n_rd1 += int'(rd1); n_rd2 += int'(rd2);
      n_done0 += int'(done0); n_done1 += int'(done1); n_done2 += int'(done2);
    end
    chk("ignore_rd_u0",   0, 32'(n_rd0),   32'd4);
    chk("ignore_done_u0", 0, 32'(n_done0), 32'd1);
    chk("ignore_rd_u1",   0, 32'(n_rd1),   32'd4);
    chk("ignore_done_u1", 0, 32'(n_done1), 32'd1);
    chk("ignore_rd_u2",   0, 32'(n_rd2),   32'd2);
    chk("ignore_done_u2", 0, 32'(n_done2), 32'd2);
    chk_idle("ignore_end", 0);

    // Reset mid-frame: asserted during cycle 3, everything clear at cycle 4.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      rst   = (c == 3);
      @(negedge clk);
      if (c == 3) chk("abort_busy_before", c, 32'(busy0), 32'd1);
    end
    chk_idle("abort", 4);
    @(posedge clk); #1; rst = 1'b0;
    n_done_abort = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_done_abort += int'(done0) + int'(done1) + int'(done2) + int'(ta0) + int'(tb1);
      @(posedge clk); #1;
    end
    chk("abort_no_done_or_tap", 0, 32'(n_done_abort), 32'd0);
    chk_idle("abort_idle", 0);

    // Fresh frame after the abort matches the basic frame.
    run_table("reframe");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
